// File: rtl/ptp_transmit_process.sv
// PTP transmit path: forwards FIFO packets to the MAC, adding (tx_ts - rx_ts) residence
// time into the 48-bit correction field of PTP packets; discards or drains on demand.
module ptp_transmit_process (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [1:0]  iv_cfg_finish,
    input  logic [8:0]  iv_data,
    input  logic        i_data_empty,
    output logic        o_data_rd,
    input  logic [18:0] timer,
    output logic [8:0]  ov_data,
    output logic        o_data_wr,
    output logic        o_fifo_underflow_pulse,
    output logic [2:0]  report_ptp_state
);

    localparam int unsigned WCNT_W = 11;
    localparam int unsigned TS_W   = 19;
    localparam int unsigned CORR_W = 48;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRANS     = 3'd1;
    localparam logic [2:0] ST_COLLECT   = 3'd2;
    localparam logic [2:0] ST_ADD       = 3'd3;
    localparam logic [2:0] ST_EMIT      = 3'd4;
    localparam logic [2:0] ST_DISC      = 3'd5;
    localparam logic [2:0] ST_UNDERFLOW = 3'd6;

    localparam logic [WCNT_W-1:0] CORR_FIRST = 11'd66;
    localparam logic [WCNT_W-1:0] CORR_LAST  = 11'd71;

    logic [2:0]        state_q,   state_d;
    logic [WCNT_W-1:0] wcnt_q,    wcnt_d;
    logic [TS_W-1:0]   tx_ts_q,   tx_ts_d;
    logic [TS_W-1:0]   rx_ts_q,   rx_ts_d;
    logic [CORR_W-1:0] corr_q,    corr_d;
    logic              is_ptp_q,  is_ptp_d;
    logic [2:0]        ecnt_q,    ecnt_d;
    logic              flush_q,   flush_d;
    logic [7:0]        last_q,    last_d;
    logic [8:0]        ov_data_q, ov_data_d;
    logic              wr_q,      wr_d;
    logic              uf_q,      uf_d;
    logic              rd_c;
    logic [2:0]        byte_sel_c;
    logic [5:0]        byte_lsb_c;

    // Correction byte k (wcnt 66+k) lands MSB-first at bit 40-8k
    assign byte_sel_c = 3'(wcnt_q - CORR_FIRST);
    assign byte_lsb_c = 6'd40 - {byte_sel_c, 3'b000};

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        tx_ts_d   = tx_ts_q;
        rx_ts_d   = rx_ts_q;
        corr_d    = corr_q;
        is_ptp_d  = is_ptp_q;
        ecnt_d    = ecnt_q;
        flush_d   = flush_q;
        last_d    = last_q;
        ov_data_d = 9'h000;
        wr_d      = 1'b0;
        uf_d      = 1'b0;
        rd_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rd_c = !i_data_empty;
                if (!i_data_empty && iv_data[8]) begin
                    wcnt_d   = 11'd1;
                    is_ptp_d = (iv_data[7:5] == 3'b100) && (iv_cfg_finish == 2'd3);
                    tx_ts_d  = timer;
                    if (iv_cfg_finish == 2'd0) begin
                        state_d = ST_DISC;
                    end else begin
                        ov_data_d = iv_data;
                        wr_d      = 1'b1;
                        state_d   = ST_TRANS;
                    end
                end
            end
            ST_TRANS: begin
                rd_c = !i_data_empty;
                if (i_data_empty) begin
                    ov_data_d = 9'h100;
                    wr_d      = 1'b1;
                    uf_d      = 1'b1;
                    state_d   = ST_UNDERFLOW;
                end else begin
                    wcnt_d = wcnt_q + 11'd1;
                    if (iv_data[8]) begin
                        ov_data_d = iv_data;
                        wr_d      = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (is_ptp_q && wcnt_q == CORR_FIRST) begin
                        corr_d[byte_lsb_c +: 8] = iv_data[7:0];
                        state_d                 = ST_COLLECT;
                    end else begin
                        ov_data_d = iv_data;
                        wr_d      = 1'b1;
                        if (is_ptp_q && wcnt_q == 11'd11) rx_ts_d[18:16] = iv_data[2:0];
                        if (is_ptp_q && wcnt_q == 11'd12) rx_ts_d[15:8]  = iv_data[7:0];
                        if (is_ptp_q && wcnt_q == 11'd13) rx_ts_d[7:0]   = iv_data[7:0];
                    end
                end
            end
            ST_COLLECT: begin
                rd_c = !i_data_empty;
                if (i_data_empty) begin
                    ov_data_d = 9'h100;
                    wr_d      = 1'b1;
                    uf_d      = 1'b1;
                    state_d   = ST_UNDERFLOW;
                end else begin
                    wcnt_d = wcnt_q + 11'd1;
                    if (iv_data[8]) begin
                        // Short packet: replay the stored bytes untouched, then the last word
                        last_d  = iv_data[7:0];
                        ecnt_d  = byte_sel_c;
                        flush_d = 1'b1;
                        state_d = ST_EMIT;
                    end else begin
                        corr_d[byte_lsb_c +: 8] = iv_data[7:0];
                        if (wcnt_q == CORR_LAST) state_d = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                corr_d  = corr_q + CORR_W'(TS_W'(tx_ts_q - rx_ts_q));
                ecnt_d  = 3'd6;
                flush_d = 1'b0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                wr_d = 1'b1;
                if (ecnt_q != 3'd0) begin
                    ov_data_d = {1'b0, corr_q[CORR_W-1 -: 8]};
                    corr_d    = {corr_q[CORR_W-9:0], 8'h00};
                    ecnt_d    = ecnt_q - 3'd1;
                    if (ecnt_q == 3'd1 && !flush_q) state_d = ST_TRANS;
                end else begin
                    ov_data_d = {1'b1, last_q};
                    flush_d   = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DISC, ST_UNDERFLOW: begin
                rd_c = !i_data_empty;
                if (!i_data_empty) begin
                    wcnt_d = wcnt_q + 11'd1;
                    if (iv_data[8]) state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            tx_ts_q   <= '0;
            rx_ts_q   <= '0;
            corr_q    <= '0;
            is_ptp_q  <= 1'b0;
            ecnt_q    <= '0;
            flush_q   <= 1'b0;
            last_q    <= '0;
            ov_data_q <= '0;
            wr_q      <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            tx_ts_q   <= tx_ts_d;
            rx_ts_q   <= rx_ts_d;
            corr_q    <= corr_d;
            is_ptp_q  <= is_ptp_d;
            ecnt_q    <= ecnt_d;
            flush_q   <= flush_d;
            last_q    <= last_d;
            ov_data_q <= ov_data_d;
            wr_q      <= wr_d;
            uf_q      <= uf_d;
        end
    end

    // Pop must stay low while reset is held, whatever the FIFO shows
    assign o_data_rd              = reset_n & rd_c;
    assign ov_data                = ov_data_q;
    assign o_data_wr              = wr_q;
    assign o_fifo_underflow_pulse = uf_q;
    assign report_ptp_state       = state_q;

endmodule

// File: tb/tb_ptp_transmit_process.sv
// Bench for ptp_transmit_process: a FIFO model feeds tagged packets, a packet-level
// model predicts the output word stream, and a scoreboard compares every written word.
module tb_ptp_transmit_process;

    localparam int MAXP = 80;
    localparam int MAXL = 128;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  iv_cfg_finish;
    logic [8:0]  iv_data;
    logic        i_data_empty;
    logic        o_data_rd;
    logic [18:0] timer;
    logic [8:0]  ov_data;
    logic        o_data_wr;
    logic        o_fifo_underflow_pulse;
    logic [2:0]  report_ptp_state;

    ptp_transmit_process dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .iv_cfg_finish(iv_cfg_finish),
        .iv_data(iv_data),
        .i_data_empty(i_data_empty),
        .o_data_rd(o_data_rd),
        .timer(timer),
        .ov_data(ov_data),
        .o_data_wr(o_data_wr),
        .o_fifo_underflow_pulse(o_fifo_underflow_pulse),
        .report_ptp_state(report_ptp_state)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [8:0] w;
        int         pkt;
        int         idx;
        int         pre;
    } ent_t;

    ent_t       fifo[$];
    logic [8:0] pk_w [MAXP][MAXL];
    int         pk_len [MAXP];
    int         pk_cfg [MAXP];
    int         pk_uf [MAXP];
    int         pk_force [MAXP];
    int         pk_gap [MAXP];
    int         pk_pop0 [MAXP];
    int         npk = 0;

    logic [8:0] exp_q[$];
    logic [8:0] log_w[$];
    int         log_c[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         exp_pulses = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Packet-level prediction of what the MAC must receive
    function automatic void build(input int p, input logic [18:0] ts);
        logic [8:0]  o[$];
        logic [18:0] rx;
        logic [47:0] c;
        bit          ptp;
        int          n;
        int          keep;
        n = pk_len[p];
        if (pk_cfg[p] == 0) return;
        for (int i = 0; i < n; i++) o.push_back(pk_w[p][i]);
        ptp = (pk_w[p][0][7:5] == 3'b100) && (pk_cfg[p] == 3);
        if (ptp && n >= 73) begin
            rx = {pk_w[p][11][2:0], pk_w[p][12][7:0], pk_w[p][13][7:0]};
            c  = '0;
            for (int k = 0; k < 6; k++) c = {c[39:0], pk_w[p][66+k][7:0]};
            c = c + {29'd0, 19'(ts - rx)};
            for (int k = 0; k < 6; k++) begin
                o[66+k] = {1'b0, c[47:40]};
                c       = c << 8;
            end
        end
        keep = n;
        if (pk_uf[p] > 0) begin
            keep = (ptp && pk_uf[p] >= 67) ? 66 : pk_uf[p];
            exp_pulses++;
        end
        for (int i = 0; i < keep; i++) exp_q.push_back(o[i]);
        if (pk_uf[p] > 0) exp_q.push_back(9'h100);
    endfunction

    task automatic new_pkt(input int len, input int cfg, input logic [2:0] typ, input int uf,
                           input int force_ts, input int gap, output int p);
        p = npk;
        npk++;
        pk_len[p]   = len;
        pk_cfg[p]   = cfg;
        pk_uf[p]    = uf;
        pk_force[p] = force_ts;
        pk_gap[p]   = gap;
        for (int i = 0; i < len; i++) pk_w[p][i] = {1'b0, 8'($urandom)};
        pk_w[p][0]     = {1'b1, typ, 5'($urandom)};
        pk_w[p][len-1] = {1'b1, 8'($urandom)};
    endtask

    task automatic enqueue(input int p);
        ent_t e;
        for (int i = 0; i < pk_len[p]; i++) begin
            e.w   = pk_w[p][i];
            e.pkt = p;
            e.idx = i;
            e.pre = (i == 0) ? pk_gap[p] :
                    (pk_uf[p] > 0 && i == pk_uf[p]) ? int'($urandom_range(1, 3)) : 0;
            fifo.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo.size() > 0 || exp_q.size() > 0) && n < budget) begin
            @(posedge clk_sys);
            n++;
        end
        repeat (12) @(posedge clk_sys);
        @(negedge clk_sys);
        check("drain_left", 64'(fifo.size() + exp_q.size()), 0);
    endtask

    // FIFO model: show-ahead head, pops on o_data_rd, programmable empty gaps
    initial begin
        ent_t        h;
        bit          pop;
        logic [18:0] ts_at;
        int          pc;
        iv_data       = '0;
        i_data_empty  = 1'b1;
        iv_cfg_finish = '0;
        timer         = '0;
        forever begin
            @(negedge clk_sys);
            pop   = o_data_rd && !i_data_empty;
            ts_at = timer;
            pc    = cyc;
            @(posedge clk_sys);
            #1;
            if (pop && fifo.size() > 0) begin
                h = fifo.pop_front();
                if (h.idx == 0) begin
                    pk_pop0[h.pkt] = pc;
                    build(h.pkt, ts_at);
                end
            end
            if (fifo.size() > 0 && fifo[0].pre > 0) begin
                h = fifo[0];
                h.pre--;
                fifo[0]      = h;
                i_data_empty = 1'b1;
                iv_data      = 9'($urandom);
            end else if (fifo.size() > 0) begin
                i_data_empty = 1'b0;
                iv_data      = fifo[0].w;
            end else begin
                i_data_empty = 1'b1;
                iv_data      = 9'($urandom);
            end
            if (fifo.size() > 0 && fifo[0].idx == 0) iv_cfg_finish = 2'(pk_cfg[fifo[0].pkt]);
            else                                     iv_cfg_finish = 2'($urandom_range(0, 3));
            if (fifo.size() > 0 && fifo[0].idx == 0 && pk_force[fifo[0].pkt] >= 0)
                timer = 19'(pk_force[fifo[0].pkt]);
            else
                timer = timer + 19'd1;
        end
    end

    // Scoreboard: every written word against the model; reset values while reset is low
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                check("reset_outputs",
                      {ov_data, o_data_wr, o_fifo_underflow_pulse, o_data_rd, report_ptp_state}, 0);
            end else begin
                if (o_data_wr) begin
                    log_w.push_back(ov_data);
                    log_c.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_extra: got %0h expected no write (cycle %0d)", ov_data, cyc);
                    end else begin
                        check("stream", ov_data, exp_q.pop_front());
                    end
                end
                if (o_fifo_underflow_pulse) begin
                    pulses++;
                    check("uf_word", {o_data_wr, ov_data}, {1'b1, 9'h100});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        int         q;
        int         n;
        int         pulses0;
        int         len;
        int         cfg;
        int         uf;
        logic [2:0] typ;
        logic [7:0] exp6 [6];

        repeat (3) @(posedge clk_sys);
        #2 reset_n = 1'b1;

        // Non-PTP 80-word packet: identical words, 1-cycle latency, no gaps
        log_w.delete(); log_c.delete();
        new_pkt(80, 3, 3'b011, 0, -1, 2, p);
        enqueue(p);
        drain(2000);
        check("t1_count", 64'(log_w.size()), 80);
        if (log_w.size() == 80) begin
            check("t1_latency", 64'(log_c[0] - pk_pop0[p]), 1);
            check("t1_nogap", 64'(log_c[79] - log_c[0]), 79);
            check("t1_last", log_w[79], pk_w[p][79]);
        end

        // PTP: rx 0x00100, tx 0x00350, corr 0 -> 0x250; 7-cycle gap before the field
        log_w.delete(); log_c.delete();
        new_pkt(80, 3, 3'b100, 0, 'h350, 2, p);
        pk_w[p][11] = {1'b0, 5'($urandom), 3'b000};
        pk_w[p][12] = 9'h001;
        pk_w[p][13] = 9'h000;
        for (int k = 0; k < 6; k++) pk_w[p][66+k] = 9'h000;
        enqueue(p);
        drain(2000);
        exp6[0] = 8'h00; exp6[1] = 8'h00; exp6[2] = 8'h00;
        exp6[3] = 8'h00; exp6[4] = 8'h02; exp6[5] = 8'h50;
        check("t2_count", 64'(log_w.size()), 80);
        if (log_w.size() == 80) begin
            for (int k = 0; k < 6; k++) check("t2_corr", log_w[66+k], {1'b0, exp6[k]});
            check("t2_gap", 64'(log_c[66] - log_c[65]), 8);
            check("t2_resume", 64'(log_c[72] - log_c[71]), 1);
        end

        // PTP timestamp wrap and 48-bit correction wrap
        log_w.delete(); log_c.delete();
        new_pkt(80, 3, 3'b100, 0, 'h10, 2, p);
        pk_w[p][11] = {1'b0, 5'($urandom), 3'b111};
        pk_w[p][12] = 9'h0FF;
        pk_w[p][13] = 9'h0F0;
        for (int k = 0; k < 5; k++) pk_w[p][66+k] = 9'h0FF;
        pk_w[p][71] = 9'h0F0;
        enqueue(p);
        drain(2000);
        exp6[0] = 8'h00; exp6[1] = 8'h00; exp6[2] = 8'h00;
        exp6[3] = 8'h00; exp6[4] = 8'h00; exp6[5] = 8'h10;
        check("t3_count", 64'(log_w.size()), 80);
        if (log_w.size() == 80)
            for (int k = 0; k < 6; k++) check("t3_corr", log_w[66+k], {1'b0, exp6[k]});

        // Discard mode, three back-to-back packets
        log_w.delete(); log_c.delete();
        new_pkt(10, 0, 3'b100, 0, -1, 0, p); enqueue(p);
        new_pkt(20, 0, 3'b011, 0, -1, 0, p); enqueue(p);
        new_pkt(5, 0, 3'b100, 0, -1, 0, p);  enqueue(p);
        drain(2000);
        check("t4_no_write", 64'(log_w.size()), 0);
        check("t4_state", report_ptp_state, 0);

        // Underflow at wcnt 30, then a clean packet
        log_w.delete(); log_c.delete();
        pulses0 = pulses;
        new_pkt(50, 2, 3'b011, 30, -1, 1, p); enqueue(p);
        new_pkt(20, 1, 3'b100, 0, -1, 0, q);  enqueue(q);
        drain(2000);
        check("t5_count", 64'(log_w.size()), 51);
        if (log_w.size() == 51) begin
            check("t5_uf_word", log_w[30], 9'h100);
            check("t5_next_first", log_w[31], pk_w[q][0]);
        end
        check("t5_pulses", 64'(pulses - pulses0), 1);
        check("t5_state", report_ptp_state, 0);

        // 69-word PTP packet ending inside the correction field
        log_w.delete(); log_c.delete();
        new_pkt(69, 3, 3'b100, 0, -1, 1, p);
        enqueue(p);
        drain(2000);
        check("t6_count", 64'(log_w.size()), 69);
        if (log_w.size() == 69) begin
            check("t6_b66", log_w[66], pk_w[p][66]);
            check("t6_b67", log_w[67], pk_w[p][67]);
            check("t6_last", log_w[68], pk_w[p][68]);
        end
        check("t6_state", report_ptp_state, 0);

        // Reset mid-packet: tail (bit8=0) words dropped, next packet forwarded
        new_pkt(40, 3, 3'b011, 0, -1, 0, p);
        enqueue(p);
        n = 0;
        while (fifo.size() > 25 && n < 2000) begin
            @(posedge clk_sys);
            n++;
        end
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        exp_q.delete();
        void'(fifo.pop_back());
        repeat (3) @(posedge clk_sys);
        #2 reset_n = 1'b1;
        log_w.delete(); log_c.delete();
        new_pkt(12, 1, 3'b011, 0, -1, 0, q);
        enqueue(q);
        drain(2000);
        check("t7_count", 64'(log_w.size()), 12);
        if (log_w.size() == 12) check("t7_first", log_w[0], pk_w[q][0]);

        // Randomized traffic against the packet model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(2, 12);
                1:       len = $urandom_range(60, 75);
                2:       len = $urandom_range(76, 120);
                default: len = $urandom_range(13, 59);
            endcase
            cfg = $urandom_range(0, 3);
            typ = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom);
            uf  = 0;
            if ($urandom_range(0, 4) == 0 && len >= 3)
                uf = $urandom_range(1, (typ == 3'b100 && cfg == 3 && len - 2 > 71) ? 71 : len - 2);
            new_pkt(len, cfg, typ, uf, -1, $urandom_range(0, 2), p);
            enqueue(p);
        end
        drain(20000);
        check("pulse_total", 64'(pulses), 64'(exp_pulses));
        check("final_state", report_ptp_state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ptp_transmit_process.md
PTP_TRANSMIT_PROCESS -- requirements
Module: ptp_transmit_process

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports: clk_sys (in, 1, system clock) and reset_n (in, 1, async active-low reset).
REQ-002 SHALL have port iv_cfg_finish (in, 2): 0 = discard all packets; 1 or 2 = forward packets unmodified; 3 = forward packets with PTP correction.
REQ-003 SHALL have port iv_data (in, 9): show-ahead FIFO word; bit8=1 marks both the first and the last word of a packet; [7:0] is the byte.
REQ-004 SHALL have port i_data_empty (in, 1): FIFO empty; iv_data is valid only when this is 0.
REQ-005 SHALL have port o_data_rd (out, 1): FIFO pop; combinational; the current iv_data is consumed in any cycle where o_data_rd=1.
REQ-006 SHALL have port timer (in, 19): free-running local timestamp; wraps modulo 2^19.
REQ-007 SHALL have port ov_data (out, 9): registered output word to the MAC TX path; same framing as iv_data.
REQ-008 SHALL have port o_data_wr (out, 1): ov_data valid; the MAC accepts one word every cycle, with no backpressure.
REQ-009 SHALL have port o_fifo_underflow_pulse (out, 1): 1-cycle pulse on a mid-packet FIFO underflow.
REQ-010 SHALL have port report_ptp_state (out, 3): current FSM state encoding.

Function
REQ-011 SHALL have FSM states IDLE=0, TRANS=1, COLLECT=2, ADD=3, EMIT=4, DISC=5, UNDERFLOW=6; any other encoding returns to IDLE with all outputs deasserted.
REQ-012 SHALL assert o_data_rd = !i_data_empty in IDLE, TRANS, COLLECT, DISC and UNDERFLOW, and 0 in ADD and EMIT.
REQ-013 SHALL maintain word counter wcnt[10:0], which is 0 for the first word and increments on every popped word of the packet.
REQ-014 In IDLE, a pop with iv_data[8]=0 SHALL discard the word and stay in IDLE (resynchronisation).
REQ-015 In IDLE, a pop with iv_data[8]=1 and iv_cfg_finish=0 SHALL discard the word, output nothing and go to DISC.
REQ-016 In IDLE, a pop with iv_data[8]=1 and iv_cfg_finish!=0 SHALL output the word next cycle (o_data_wr=1) and go to TRANS.
REQ-017 On that same first-word pop, the block SHALL capture is_ptp = (iv_data[7:5]==3'b100 && iv_cfg_finish==3) and tx_ts = timer.
REQ-018 Latency SHALL be 1 cycle from pop to ov_data/o_data_wr for every directly forwarded word.
REQ-019 In TRANS, for an is_ptp packet, the block SHALL capture rx_ts[18:16]=iv_data[2:0] at wcnt 11, rx_ts[15:8] at wcnt 12 and rx_ts[7:0] at wcnt 13; these words are forwarded unchanged.
REQ-020 In TRANS, a popped word with bit8=0 SHALL be forwarded.
REQ-021 In TRANS, for an is_ptp packet, the word at wcnt 66 SHALL NOT be output; it is stored in corr[47:40] and the FSM goes to COLLECT.
REQ-022 In TRANS, a popped word with bit8=1 SHALL be forwarded and the FSM returns to IDLE.
REQ-023 In COLLECT, the words at wcnt 67..71 SHALL be stored MSB-first into corr[39:0] with no output; after wcnt 71 the FSM goes to ADD.
REQ-024 In ADD (1 cycle, no pop, no output), the block SHALL compute res = (tx_ts - rx_ts) mod 2^19, zero-extended to 48 bits, and corr = (corr + res) mod 2^48.
REQ-025 In EMIT, the block SHALL output corr as 6 words MSB-first ({1'b0,byte}, o_data_wr=1 each cycle, 6 cycles) and then return to TRANS.
REQ-026 If a bit8=1 word is popped in COLLECT, the block SHALL output the stored bytes unmodified MSB-first, then the last word, then go to IDLE; no pop occurs during that flush.
REQ-027 If i_data_empty=1 in TRANS or COLLECT, the block SHALL output {1'b1,8'h00} with o_data_wr=1, pulse o_fifo_underflow_pulse for 1 cycle and go to UNDERFLOW; any collected bytes are dropped.
REQ-028 In DISC and UNDERFLOW, the block SHALL pop with no output until a bit8=1 word is popped, then go to IDLE.
REQ-029 When not is_ptp, the packet SHALL pass through bit-exact with no extra cycles.
REQ-030 iv_cfg_finish SHALL be sampled only on the first word; changes mid-packet have no effect.

Reset
REQ-031 While reset_n=0, the block SHALL hold ov_data=0, o_data_wr=0, o_fifo_underflow_pulse=0, o_data_rd=0, state=IDLE and wcnt, tx_ts, rx_ts, corr, is_ptp all 0.
REQ-032 Reset asserted mid-packet SHALL abort the packet immediately; after release, the remaining words (bit8=0) are dropped in IDLE per REQ-014.

Verification
REQ-033 Bench SHALL cover: cfg=3, 80-word non-PTP packet (type 3'b011) -> 80 identical words out, 1-cycle latency, no gaps.
REQ-034 Bench SHALL cover: cfg=3, 80-word PTP packet, rx_ts=19'h00100, timer=19'h00350 at first pop, corr=48'h0 -> bytes 66..71 out = 00 00 00 00 02 50; the output gap is 7 cycles.
REQ-035 Bench SHALL cover: PTP packet with rx_ts=19'h7FFF0, tx_ts=19'h00010, corr=48'hFFFF_FFFF_FFF0 -> res=0x20; corr out=48'h0000_0000_0010 (48-bit wrap).
REQ-036 Bench SHALL cover: cfg=0, 3 back-to-back packets -> o_data_wr never asserted; all words popped; state ends in IDLE.
REQ-037 Bench SHALL cover: empty asserted at wcnt 30 of a packet -> output word 9'h100, one underflow pulse, remainder drained and not forwarded; the next packet is forwarded correctly.
REQ-038 Bench SHALL cover: a 69-word PTP packet (last word at wcnt 68) -> bytes 66..67 unmodified, then the last word, 69 words out, FSM returns to IDLE.
